// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    DONE
  } stateT;

  // rs1 is treated as two's complement for these operations.
  function automatic logic isSignedA(input logic [2:0] funct3);
    return funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  // rs2 is treated as two's complement for these operations.
  function automatic logic isSignedB(input logic [2:0] funct3);
    return funct3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring divide on unsigned magnitudes.
// Multiply: {hi,lo} holds {partial product, remaining multiplier}, operand = multiplicand.
// Divide:   {hi,lo} holds {partial remainder, dividend/quotient}, operand = divisor.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            isDiv,
  input  logic [XLEN-1:0] hiIn,
  input  logic [XLEN-1:0] loIn,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hiOut,
  output logic [XLEN-1:0] loOut
);

  logic [XLEN:0] addSum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trialDiff;

  // Compute both step flavours and select the one for the current operation.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    hiOut     = hiIn;
    loOut     = loIn;
    addSum    = {1'b0, hiIn} + (loIn[0] ? {1'b0, operand} : '0);
    shifted   = {hiIn, loIn[XLEN-1]};
    // The partial remainder stays below the divisor, so bit XLEN of the
    // difference is set exactly when the trial subtraction would go negative.
    trialDiff = shifted - {1'b0, operand};
    if (isDiv) begin
      if (!trialDiff[XLEN]) begin
        hiOut = trialDiff[XLEN-1:0];
        loOut = {loIn[XLEN-2:0], 1'b1};
      end else begin
        hiOut = shifted[XLEN-1:0];
        loOut = {loIn[XLEN-2:0], 1'b0};
      end
    end else begin
      hiOut = addSum[XLEN:1];
      loOut = {addSum[0], loIn[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit with valid/ready handshakes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iValid,
  output logic            oReady,
  input  logic [XLEN-1:0] iDataA,
  input  logic [XLEN-1:0] iDataB,
  input  logic [2:0]      iFunct3,
  input  logic [6:0]      iFunct7,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oData,
  output logic            oZero,
  output logic            oIllegal
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  stateT           state, nextState;
  logic [XLEN-1:0] opA, opB, accHi, accLo, stepOp;
  logic [XLEN-1:0] iterHi, iterLo, specialData, finalData;
  logic [XLEN-1:0] quotient, remainder;
  logic [2*XLEN-1:0] product;
  logic [2:0]      funct3Q;
  logic [6:0]      funct7Q;
  logic [CW-1:0]   count;
  logic            negQ, negR, negA, negB;
  logic            accept, illegalIn, divZeroIn, overflowIn, specialIn, lastIter;

  assign oReady   = (state == IDLE);
  assign oValid   = (state == DONE);
  assign oZero    = oValid && (oData == '0);
  assign oIllegal = oValid && (funct7Q != FUNCT7_MULDIV);

  assign accept     = iValid && oReady;
  assign illegalIn  = (iFunct7 != FUNCT7_MULDIV);
  assign divZeroIn  = iFunct3[2] && (iDataB == '0);
  assign overflowIn = (iFunct3 == F3_DIV || iFunct3 == F3_REM) &&
                      (iDataA == MIN_NEG) && (iDataB == '1);
  assign specialIn  = illegalIn || divZeroIn || overflowIn;
  assign lastIter   = (count == CW'(XLEN - 1));
  assign negA       = isSignedA(funct3Q) && opA[XLEN-1];
  assign negB       = isSignedB(funct3Q) && opB[XLEN-1];

  muldiv_iter #(.XLEN(XLEN)) uIter (
    .isDiv   (funct3Q[2]),
    .hiIn    (accHi),
    .loIn    (accLo),
    .operand (stepOp),
    .hiOut   (iterHi),
    .loOut   (iterLo)
  );

  // Results that bypass the iterative datapath, decided from the request itself.
  always_comb begin
    specialData = '0;
    if (illegalIn) begin
      specialData = '0;
    end else if (divZeroIn) begin
      specialData = iFunct3[1] ? iDataA : '1;
    end else if (overflowIn) begin
      specialData = iFunct3[1] ? '0 : iDataA;
    end
  end

  // Re-apply signs to the magnitude result of the final iteration and pick the field.
  always_comb begin
    product   = negQ ? -{iterHi, iterLo} : {iterHi, iterLo};
    quotient  = negQ ? -iterLo : iterLo;
    remainder = negR ? -iterHi : iterHi;
    finalData = product[XLEN-1:0];
    unique case (funct3Q)
      F3_MUL:                       finalData = product[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: finalData = product[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              finalData = quotient;
      default:                      finalData = remainder;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
    if (!iRstN) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; DONE waits for the consumer, and IDLE is only re-entered from DONE.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = specialIn ? DONE : PREP;
      PREP:    nextState = CALC;
      CALC:    if (lastIter) nextState = DONE;
      DONE:    if (iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, sign preparation, iteration and result registering.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      opA     <= '0;
      opB     <= '0;
      funct3Q <= '0;
      funct7Q <= FUNCT7_MULDIV;
      accHi   <= '0;
      accLo   <= '0;
      stepOp  <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      count   <= '0;
      oData   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opA     <= iDataA;
            opB     <= iDataB;
            funct3Q <= iFunct3;
            funct7Q <= iFunct7;
            if (specialIn) oData <= specialData;
          end
        end
        PREP: begin
          accHi  <= '0;
          accLo  <= negA ? -opA : opA;
          stepOp <= negB ? -opB : opB;
          negQ   <= negA ^ negB;
          negR   <= negA;
          count  <= '0;
        end
        CALC: begin
          accHi <= iterHi;
          accLo <= iterLo;
          count <= count + 1'b1;
          if (lastIter) oData <= finalData;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, legal range 4..64.
REQ-002 SHALL have port iClk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port iRstN, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port iValid, input, 1: request valid.
REQ-005 SHALL have port oReady, output, 1: unit can accept a request.
REQ-006 SHALL have port iDataA, input, XLEN: rs1 operand.
REQ-007 SHALL have port iDataB, input, XLEN: rs2 operand.
REQ-008 SHALL have port iFunct3, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port iFunct7, input, 7: must equal 0000001 (M-extension).
REQ-010 SHALL have port oValid, output, 1: result valid.
REQ-011 SHALL have port iReady, input, 1: consumer accepts result.
REQ-012 SHALL have port oData, output, XLEN: result.
REQ-013 SHALL have port oZero, output, 1: oData == 0, qualified by oValid.
REQ-014 SHALL have port oIllegal, output, 1: request had iFunct7 != 0000001, qualified by oValid.

Function
REQ-015 SHALL use FSM states IDLE, PREP, CALC, DONE; oReady = (state == IDLE).
REQ-016 SHALL accept a request on a rising edge with iValid && oReady, latching iDataA, iDataB, iFunct3 and iFunct7; inputs are ignored in all other states.
REQ-017 On acceptance, SHALL go to DONE in 1 cycle for special cases (REQ-022..024), otherwise to PREP.
REQ-018 PREP SHALL take absolute values of signed operands and record result sign, then go to CALC with iteration counter 0.
REQ-019 CALC SHALL run exactly XLEN iterations: radix-2 shift-add multiply (2*XLEN-bit product) or restoring divide (XLEN-bit quotient and remainder), then go to DONE.
REQ-020 Normal latency SHALL be XLEN+1 edges from acceptance to oValid=1 (33 for XLEN=32); special-case latency SHALL be 1 edge.
REQ-021 Sign rules: MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned; quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-022 Divide by zero SHALL give DIV/DIVU = all ones and REM/REMU = A.
REQ-023 Signed overflow (DIV/REM with A = -2^(XLEN-1), B = -1) SHALL give DIV = A and REM = 0.
REQ-024 iFunct7 != 0000001 SHALL give oData = 0, oIllegal = 1, oZero = 1.
REQ-025 DONE SHALL hold oValid, oData, oZero and oIllegal stable until iValid... until iReady=1, then return to IDLE on that edge.
REQ-026 A new request SHALL NOT be accepted on the DONE->IDLE edge; the earliest new acceptance is the next edge.
REQ-027 oValid SHALL be 0 in IDLE, PREP and CALC; oData SHALL be registered, with no combinational path from inputs to outputs except none (oReady depends only on state).

Reset
REQ-028 iRstN low SHALL immediately force state IDLE, oValid 0, oData 0, oZero 0, oIllegal 0, counter 0 and operand registers 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation without ever producing a result; oReady SHALL be 1 on the first edge after deassertion.

Structure
REQ-030 Package muldiv_pkg SHALL hold the funct3 codes, the FUNCT7_MULDIV constant (0000001) and the FSM state typedef.
REQ-031 Sub-module muldiv_iter SHALL implement the one-step shift-add/restoring-divide datapath, parametrised by XLEN; the FSM, sign handling and handshake SHALL stay in muldiv_unit.
REQ-032 The design SHALL be synthesizable and SHALL NOT contain latches or use `*`, `/` or `%` operators on XLEN-wide operands.

Verification (XLEN=32)
REQ-033 MUL 7 x 6: accept at edge 0 -> oValid at edge 33, oData 0000002A, oZero 0.
REQ-034 MULH FFFFFFFF x FFFFFFFF -> 00000000, oZero 1; MULHU same operands -> FFFFFFFE; MULHSU FFFFFFFF x 00000002 -> FFFFFFFF.
REQ-035 DIV FFFFFFEC / 00000003 -> FFFFFFFA; REM same operands -> FFFFFFFE; DIVU 00000014 / 00000003 -> 00000006.
REQ-036 DIVU 5 / 0 -> FFFFFFFF after 1 edge; REMU 5 / 0 -> 00000005; DIV 80000000 / FFFFFFFF -> 80000000; REM same operands -> 00000000.
REQ-037 Backpressure: hold iReady=0 for 5 cycles in DONE -> oData stable, oReady 0; toggle iDataA during CALC -> result unchanged.
REQ-038 Pulse iRstN low at CALC iteration 10 -> oValid stays 0, oReady 1 after release; next MUL 3 x 3 -> 00000009. iFunct7=0100000 -> oIllegal 1, oData 0 after 1 edge.
